// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall control and a saturating bubble counter.
// Optional writeback-to-operand bypass is enabled by defining WB_BYPASS_EN.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall,
  input  logic             Flush,
  input  logic             in_RegWrite,
  input  logic             in_MemRead,
  input  logic             in_MemWrite,
  input  logic             in_ALUSrc,
  input  logic [2:0]       in_ALUOp,
  input  logic [4:0]       in_Rs,
  input  logic [4:0]       in_Rt,
  input  logic [4:0]       in_Rd,
  input  logic [31:0]      in_Imm,
  input  logic [31:0]      in_PC4,
  input  logic [31:0]      ReadData1,
  input  logic [31:0]      ReadData2,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_WriteReg,
  input  logic [31:0]      WB_WriteData,
  output logic             out_Valid,
  output logic             out_RegWrite,
  output logic             out_MemRead,
  output logic             out_MemWrite,
  output logic             out_ALUSrc,
  output logic [2:0]       out_ALUOp,
  output logic [4:0]       out_Rs,
  output logic [4:0]       out_Rt,
  output logic [4:0]       out_Rd,
  output logic [31:0]      out_Imm,
  output logic [31:0]      out_PC4,
  output logic [31:0]      out_A,
  output logic [31:0]      out_B,
  output logic             HazardStall,
  output logic [CNT_W-1:0] BubbleCount
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
  } stage_t;

  stage_t           stage_d, stage_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [31:0]      op_a, op_b;
  logic             hazard;

`ifdef WB_BYPASS_EN
  // Writeback lands in the register file on the same edge we capture, so forward it here.
  assign op_a = (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == in_Rs) ? WB_WriteData : ReadData1;
  assign op_b = (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == in_Rt) ? WB_WriteData : ReadData2;
`else
  logic unused_wb;
  assign unused_wb = ^{WB_RegWrite, WB_WriteReg, WB_WriteData};
  assign op_a      = ReadData1;
  assign op_b      = ReadData2;
`endif

  // A load in EX whose destination feeds the instruction now in ID must wait one cycle.
  assign hazard = stage_q.valid & stage_q.mem_read & (stage_q.rt != 5'd0) &
                  ((stage_q.rt == in_Rs) | (stage_q.rt == in_Rt));

  always_comb begin
    // NOTE: default every combinational output first so no path leaves a latch behind.
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (Flush || (!Stall && hazard)) begin
      stage_d = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (!Stall) begin
      stage_d = '{valid: 1'b1, reg_write: in_RegWrite, mem_read: in_MemRead,
                  mem_write: in_MemWrite, alu_src: in_ALUSrc, alu_op: in_ALUOp,
                  rs: in_Rs, rt: in_Rt, rd: in_Rd, imm: in_Imm, pc4: in_PC4,
                  a: op_a, b: op_b};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_Valid    = stage_q.valid;
  assign out_RegWrite = stage_q.reg_write;
  assign out_MemRead  = stage_q.mem_read;
  assign out_MemWrite = stage_q.mem_write;
  assign out_ALUSrc   = stage_q.alu_src;
  assign out_ALUOp    = stage_q.alu_op;
  assign out_Rs       = stage_q.rs;
  assign out_Rt       = stage_q.rt;
  assign out_Rd       = stage_q.rd;
  assign out_Imm      = stage_q.imm;
  assign out_PC4      = stage_q.pc4;
  assign out_A        = stage_q.a;
  assign out_B        = stage_q.b;
  assign HazardStall  = hazard;
  assign BubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (small counter width so saturation is reachable).
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, Stall, Flush;
  logic in_RegWrite, in_MemRead, in_MemWrite, in_ALUSrc;
  logic [2:0]  in_ALUOp;
  logic [4:0]  in_Rs, in_Rt, in_Rd;
  logic [31:0] in_Imm, in_PC4, ReadData1, ReadData2;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        out_Valid, out_RegWrite, out_MemRead, out_MemWrite, out_ALUSrc;
  logic [2:0]  out_ALUOp;
  logic [4:0]  out_Rs, out_Rt, out_Rd;
  logic [31:0] out_Imm, out_PC4, out_A, out_B;
  logic        HazardStall;
  logic [CNT_W-1:0] BubbleCount;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush),
    .in_RegWrite(in_RegWrite), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_ALUSrc(in_ALUSrc), .in_ALUOp(in_ALUOp),
    .in_Rs(in_Rs), .in_Rt(in_Rt), .in_Rd(in_Rd), .in_Imm(in_Imm), .in_PC4(in_PC4),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .out_Valid(out_Valid), .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead),
    .out_MemWrite(out_MemWrite), .out_ALUSrc(out_ALUSrc), .out_ALUOp(out_ALUOp),
    .out_Rs(out_Rs), .out_Rt(out_Rt), .out_Rd(out_Rd), .out_Imm(out_Imm), .out_PC4(out_PC4),
    .out_A(out_A), .out_B(out_B), .HazardStall(HazardStall), .BubbleCount(BubbleCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [31:0] rd1, input logic [31:0] rd2);
    in_MemRead = mr;
    in_Rs      = rs;
    in_Rt      = rt;
    ReadData1  = rd1;
    ReadData2  = rd2;
  endtask

  initial begin
    rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    in_RegWrite = 1'b0; in_MemRead = 1'b0; in_MemWrite = 1'b0; in_ALUSrc = 1'b0;
    in_ALUOp = 3'd0; in_Rs = 5'd0; in_Rt = 5'd0; in_Rd = 5'd0;
    in_Imm = 32'd0; in_PC4 = 32'd0; ReadData1 = 32'd0; ReadData2 = 32'd0;
    WB_RegWrite = 1'b0; WB_WriteReg = 5'd0; WB_WriteData = 32'd0;

    #3;
    check("rst_valid", 32'(out_Valid), 32'd0);
    check("rst_count", 32'(BubbleCount), 32'd0);
    check("rst_hazard", 32'(HazardStall), 32'd0);
    check("rst_a", out_A, 32'd0);

    // First edge after reset is a normal load.
    step();
    rst = 1'b1;
    in_RegWrite = 1'b1; in_ALUSrc = 1'b1; in_ALUOp = 3'd2; in_Rd = 5'd2;
    in_Imm = 32'h10; in_PC4 = 32'h104;
    set_instr(1'b0, 5'd3, 5'd4, 32'h11, 32'h22);
    step();
    check("norm_valid", 32'(out_Valid), 32'd1);
    check("norm_a", out_A, 32'h11);
    check("norm_b", out_B, 32'h22);
    check("norm_aluop", 32'(out_ALUOp), 32'd2);
    check("norm_rd", 32'(out_Rd), 32'd2);
    check("norm_imm", out_Imm, 32'h10);
    check("norm_pc4", out_PC4, 32'h104);
    check("norm_regwr", 32'(out_RegWrite), 32'd1);
    check("norm_count", 32'(BubbleCount), 32'd0);

    // Load-use: a load to r5 followed by a user of r5.
    in_RegWrite = 1'b1; in_ALUSrc = 1'b0;
    set_instr(1'b1, 5'd1, 5'd5, 32'h0, 32'h0);
    step();
    check("ld_memread", 32'(out_MemRead), 32'd1);
    check("ld_rt", 32'(out_Rt), 32'd5);
    set_instr(1'b0, 5'd0, 5'd0, 32'h55, 32'h66);
    #1;
    check("zero_regs_no_hazard", 32'(HazardStall), 32'd0);
    set_instr(1'b0, 5'd5, 5'd6, 32'h55, 32'h66);
    #1;
    check("lu_hazard", 32'(HazardStall), 32'd1);
    step();
    check("lu_bubble_valid", 32'(out_Valid), 32'd0);
    check("lu_bubble_memread", 32'(out_MemRead), 32'd0);
    check("lu_count", 32'(BubbleCount), 32'd1);
    check("lu_hazard_clear", 32'(HazardStall), 32'd0);
    step();
    check("lu_retry_valid", 32'(out_Valid), 32'd1);
    check("lu_retry_rs", 32'(out_Rs), 32'd5);
    check("lu_retry_a", out_A, 32'h55);

    // Stall with a pending hazard holds everything; flush beats stall.
    set_instr(1'b1, 5'd1, 5'd5, 32'h0, 32'h0);
    step();
    set_instr(1'b0, 5'd5, 5'd0, 32'h77, 32'h0);
    Stall = 1'b1;
    step();
    check("stall_valid", 32'(out_Valid), 32'd1);
    check("stall_memread", 32'(out_MemRead), 32'd1);
    check("stall_rt", 32'(out_Rt), 32'd5);
    check("stall_count", 32'(BubbleCount), 32'd1);
    check("stall_hazard", 32'(HazardStall), 32'd1);
    Flush = 1'b1;
    step();
    check("flush_stall_valid", 32'(out_Valid), 32'd0);
    check("flush_stall_regwr", 32'(out_RegWrite), 32'd0);
    check("flush_stall_count", 32'(BubbleCount), 32'd2);
    Flush = 1'b0; Stall = 1'b0;

    // Writeback bypass onto operand B.
    WB_RegWrite = 1'b1; WB_WriteReg = 5'd7; WB_WriteData = 32'hDEAD;
    set_instr(1'b0, 5'd2, 5'd7, 32'h33, 32'h0);
    step();
    check("byp_a", out_A, 32'h33);
`ifdef WB_BYPASS_EN
    check("byp_b", out_B, 32'hDEAD);
`else
    check("byp_b", out_B, 32'h0);
`endif
    WB_WriteReg = 5'd0;
    step();
    check("byp_r0_b", out_B, 32'h0);
    WB_RegWrite = 1'b0;

    // Async reset mid-hazard-stall.
    set_instr(1'b1, 5'd1, 5'd9, 32'h0, 32'h0);
    step();
    set_instr(1'b0, 5'd9, 5'd0, 32'h44, 32'h0);
    Stall = 1'b1;
    step();
    check("pre_arst_valid", 32'(out_Valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_Valid), 32'd0);
    check("arst_count", 32'(BubbleCount), 32'd0);
    check("arst_hazard", 32'(HazardStall), 32'd0);
    check("arst_memread", 32'(out_MemRead), 32'd0);
    Stall = 1'b0;
    #1;
    rst = 1'b1;
    step();
    check("post_arst_valid", 32'(out_Valid), 32'd1);
    check("post_arst_a", out_A, 32'h44);

    // Saturation at 15 for a 4-bit counter.
    Flush = 1'b1;
    for (int i = 0; i < 14; i++) step();
    check("sat_14", 32'(BubbleCount), 32'd14);
    for (int i = 0; i < 3; i++) step();
    check("sat_17", 32'(BubbleCount), 32'd15);
    check("sat_valid", 32'(out_Valid), 32'd0);
    Flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CNT_W, default 16: width of the bubble counter.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Stall  input  1  external hold request from a later stage.
REQ-005 Flush  input  1  squash the instruction entering the stage (branch/jump redirect).
REQ-006 in_RegWrite, in_MemRead, in_MemWrite, in_ALUSrc  input  1 each  decode control bits.
REQ-007 in_ALUOp  input  3  decode ALU operation.
REQ-008 in_Rs, in_Rt, in_Rd  input  5 each  decode register specifiers.
REQ-009 in_Imm, in_PC4  input  32 each  sign-extended immediate; PC+4.
REQ-010 ReadData1, ReadData2  input  32 each  register-file read ports for in_Rs, in_Rt.
REQ-011 WB_RegWrite  input  1; WB_WriteReg  input  5; WB_WriteData  input  32: writeback port, the same values driven into the register file.
REQ-012 out_Valid plus out_<field> for every in_ field  output  matching width  registered stage contents.
REQ-013 out_A, out_B  output  32 each  registered operands.
REQ-014 HazardStall  output  1  load-use hazard; upstream holds PC and IF/ID while asserted.
REQ-015 BubbleCount  output  CNT_W  bubbles inserted since reset.

Function
REQ-016 Per-edge priority SHALL be: Flush > Stall > hazard bubble > normal load.
REQ-017 Flush=1 SHALL load a bubble: out_Valid=0, out_RegWrite/MemRead/MemWrite/ALUSrc=0, out_ALUOp=0; data fields SHALL be don't-care, implemented as 0.
REQ-018 Flush=0, Stall=1 SHALL hold every register, BubbleCount included, unchanged.
REQ-019 HazardStall SHALL be combinational and equal to out_Valid & out_MemRead & (out_Rt!=0) & (out_Rt==in_Rs | out_Rt==in_Rt).
REQ-020 Flush=0, Stall=0, HazardStall=1 SHALL load a bubble as in REQ-017.
REQ-021 Otherwise the stage SHALL capture all in_ fields, out_A/out_B from the operand path, and out_Valid=1.
REQ-022 Latency SHALL be exactly one cycle from input to out_ registers.
REQ-023 BubbleCount SHALL increment by 1 on each edge that loads a bubble (REQ-017 or REQ-020).
REQ-024 BubbleCount SHALL saturate at all-ones and never wrap.
REQ-025 in_Rs or in_Rt equal to 0 SHALL never raise HazardStall.

Reset
REQ-026 rst=0 SHALL immediately, without waiting for clk, clear out_Valid, all out_ control bits, out_ data fields, out_A, out_B and BubbleCount to 0.
REQ-027 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; HazardStall SHALL then read 0.
REQ-028 The first rising edge after rst returns to 1 SHALL behave as a normal edge per REQ-016.

Configuration
REQ-029 Macro WB_BYPASS_EN compiled in: out_A SHALL take WB_WriteData when WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg==in_Rs, else ReadData1; out_B likewise against in_Rt with ReadData2.
REQ-030 Macro WB_BYPASS_EN compiled out: out_A=ReadData1 and out_B=ReadData2 unconditionally; WB_* inputs SHALL be unused.

Verification
REQ-031 Normal: in_Rs=3, ReadData1=0x11, no hazard -> next edge out_A=0x11, out_Valid=1, BubbleCount unchanged.
REQ-032 Load-use: out_MemRead=1, out_Rt=5, out_Valid=1, in_Rs=5 -> HazardStall=1; next edge out_Valid=0, BubbleCount=1.
REQ-033 Priority: Flush=1 and Stall=1 on the same edge -> bubble loaded, BubbleCount+1; Stall=1 alone with hazard -> all registers held, count unchanged.
REQ-034 Bypass: WB_RegWrite=1, WB_WriteReg=7, WB_WriteData=0xDEAD, in_Rt=7, ReadData2=0 -> out_B=0xDEAD with WB_BYPASS_EN, 0 without; WB_WriteReg=0 -> out_B=0 in both builds.
REQ-035 Saturation: CNT_W=4, 17 consecutive flushes -> BubbleCount=15.
REQ-036 Async reset: rst=0 between clock edges while out_Valid=1 -> out_Valid=0 and BubbleCount=0 at once.
